linked_list_engine: RTL

Parametrised linked-list manager holding a node memory (data + next-pointer per entry) and executing search, insert-after, delete and length commands by walking the list one node per cycle. It replaces single-purpose insert logic with a command/response handshaked engine that includes loop detection and a bulk-initialisation write port. It sits behind a controller that builds lists through the write port and then issues commands against a chosen head.

---
 rtl/linked_list_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/linked_list_engine.sv
// linked_list_engine
//   Linked-list manager over a small node memory. Each entry holds
//   {data, next}; address 0 is the null sentinel. A command engine walks a
//   list one node per cycle to execute SEARCH, INSERT_AFTER, DELETE and
//   LENGTH. A walk that has not ended after 2**ADDR_WIDTH-1 hops is
//   reported as a LOOP.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_en_i/addr/data     bulk-init node write (IDLE only, addr 0 ignored)
//   cmd_*                 command channel (valid/ready), op/head/target/new/data
//   rsp_*                 response channel (valid/ready), status/addr/count
//   rd_addr_i/rd_data_o   combinational debug read of the node memory
module linked_list_engine #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
    input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] wr_data_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [1:0]                       cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_head_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_target_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_new_addr_i,
    input  logic [DATA_WIDTH-1:0]            cmd_data_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [1:0]                       rsp_status_o,
    output logic [ADDR_WIDTH-1:0]            rsp_addr_o,
    output logic [ADDR_WIDTH-1:0]            rsp_count_o,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] rd_data_o
);

    localparam int NODE_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_LENGTH = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_LOOP      = 2'b10;
    localparam logic [1:0] ST_BAD_CMD   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_COMMIT, S_RESP} state_t;

    state_t state_q, state_d;

    logic [NODE_W-1:0]     mem_q [DEPTH];

    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [ADDR_WIDTH-1:0] new_q, new_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] curr_q, curr_d;
    logic [ADDR_WIDTH-1:0] prev_q, prev_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [ADDR_WIDTH-1:0] rsp_count_q, rsp_count_d;

    // Decode of the node currently under examination.
    logic [NODE_W-1:0]     curr_node;
    logic [DATA_WIDTH-1:0] curr_data;
    logic [ADDR_WIDTH-1:0] curr_next;
    logic                  accept, bad_cmd, curr_null, key_hit, tgt_hit, cnt_full;

    assign curr_node = mem_q[curr_q];
    assign curr_data = curr_node[NODE_W-1:ADDR_WIDTH];
    assign curr_next = curr_node[ADDR_WIDTH-1:0];

    assign accept    = cmd_valid_i && (state_q == S_IDLE);
    assign bad_cmd   = (cmd_op_i == OP_INSERT) &&
                       ((cmd_new_addr_i == '0) || (cmd_new_addr_i == cmd_target_i));
    assign curr_null = (curr_q == '0);
    assign key_hit   = (op_q == OP_SEARCH) && (curr_data == data_q);
    assign tgt_hit   = ((op_q == OP_INSERT) || (op_q == OP_DELETE)) && (curr_q == target_q);
    // Only 2**ADDR_WIDTH-1 real nodes exist, so a walk still going after
    // that many hops must be revisiting a node.
    assign cnt_full  = (count_q == '1);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = bad_cmd ? S_RESP : S_WALK;
            S_WALK: begin
                if (curr_null || key_hit) state_d = S_RESP;
                else if (tgt_hit)         state_d = S_COMMIT;
                else if (cnt_full)        state_d = S_RESP;
            end
            S_COMMIT: state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready_o  = (state_q == S_IDLE);
        rsp_valid_o  = (state_q == S_RESP);
        rsp_status_o = rsp_status_q;
        rsp_addr_o   = rsp_addr_q;
        rsp_count_o  = rsp_count_q;
        rd_data_o    = mem_q[rd_addr_i];
    end

    // Datapath next values
    always_comb begin
        op_d         = op_q;
        head_d       = head_q;
        target_d     = target_q;
        new_d        = new_q;
        data_d       = data_q;
        curr_d       = curr_q;
        prev_d       = prev_q;
        count_d      = count_q;
        rsp_status_d = rsp_status_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_count_d  = rsp_count_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                op_d     = cmd_op_i;
                head_d   = cmd_head_i;
                target_d = cmd_target_i;
                new_d    = cmd_new_addr_i;
                data_d   = cmd_data_i;
                curr_d   = cmd_head_i;
                prev_d   = '0;
                count_d  = '0;
                if (bad_cmd) begin
                    rsp_status_d = ST_BAD_CMD;
                    rsp_addr_d   = '0;
                    rsp_count_d  = '0;
                end
            end
            S_WALK: begin
                if (curr_null) begin
                    rsp_status_d = (op_q == OP_LENGTH) ? ST_OK : ST_NOT_FOUND;
                    rsp_addr_d   = '0;
                    rsp_count_d  = count_q;
                end else if (key_hit) begin
                    rsp_status_d = ST_OK;
                    rsp_addr_d   = curr_q;
                    rsp_count_d  = count_q;
                end else if (tgt_hit) begin
                    // curr/prev frozen on the target for COMMIT
                end else if (cnt_full) begin
                    rsp_status_d = ST_LOOP;
                    rsp_addr_d   = curr_q;
                    rsp_count_d  = count_q;
                end else begin
                    prev_d  = curr_q;
                    curr_d  = curr_next;
                    count_d = count_q + 1'b1;
                end
            end
            S_COMMIT: begin
                rsp_status_d = ST_OK;
                rsp_count_d  = count_q;
                if (op_q == OP_INSERT)  rsp_addr_d = new_q;
                else if (prev_q != '0)  rsp_addr_d = head_q;
                else                    rsp_addr_d = curr_next; // head removed: successor is new head
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= '0;
            head_q       <= '0;
            target_q     <= '0;
            new_q        <= '0;
            data_q       <= '0;
            curr_q       <= '0;
            prev_q       <= '0;
            count_q      <= '0;
            rsp_status_q <= '0;
            rsp_addr_q   <= '0;
            rsp_count_q  <= '0;
        end else begin
            op_q         <= op_d;
            head_q       <= head_d;
            target_q     <= target_d;
            new_q        <= new_d;
            data_q       <= data_d;
            curr_q       <= curr_d;
            prev_q       <= prev_d;
            count_q      <= count_d;
            rsp_status_q <= rsp_status_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_count_q  <= rsp_count_d;
        end
    end

    // Node memory. Init writes only happen in IDLE and structural edits only
    // in COMMIT, so the two never collide. All COMMIT writes share one edge,
    // which keeps every list edit atomic. In COMMIT curr_q is the target.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en_i && (state_q == S_IDLE) && (wr_addr_i != '0))
                mem_q[wr_addr_i] <= wr_data_i;
            if (state_q == S_COMMIT) begin
                if (op_q == OP_INSERT) begin
                    mem_q[new_q]                   <= {data_q, curr_next};
                    mem_q[curr_q][ADDR_WIDTH-1:0]  <= new_q;
                end else begin
                    if (prev_q != '0)
                        mem_q[prev_q][ADDR_WIDTH-1:0] <= curr_next;
                    mem_q[curr_q][ADDR_WIDTH-1:0] <= '0;
                end
            end
        end
    end

endmodule
